mc_ctrl_fsm: RTL and testbench

Multi-cycle main controller for the RV32I core. It sequences instruction fetch, decode, execute, memory and write-back over several cycles, sharing one ALU and one memory port. It drives every datapath select: `BSel` for the ALU B-operand mux, `ASel`, `ImmSel`, `ALUSel`, `WBSel` and `PCSel`. It also drives all write enables (PC, IR, ALU-out register, register file) and the memory request/ready handshake.

---
 rtl/rv32i_ctrl_pkg.sv | 78 +++++++
 rtl/mc_alu_decoder.sv | 54 +++++
 rtl/mc_ctrl_fsm.sv | 188 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path.
//
// Contents:
//   ctrl_state_e   - controller state encoding (FETCH .. HALT)
//   OPC_*          - the nine base RV32I major opcodes the controller accepts
//   ALU_*          - ALUSel encoding driven to the datapath ALU
//   IMM_*          - ImmSel encoding driven to the immediate generator
//   WB_*           - WBSel encoding driven to the register-file write mux
//   opcodeIsLegal  - true for any opcode the controller knows how to sequence
//   immSelFor      - immediate format used by a given opcode
package rv32i_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Anything outside the nine base opcodes sends the controller to HALT.
    function automatic logic opcodeIsLegal(input logic [6:0] opc);
        logic legal;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // OP has no immediate; it falls back to I so the field is never X.
    function automatic logic [2:0] immSelFor(input logic [6:0] opc);
        logic [2:0] sel;
        case (opc)
            OPC_STORE:            sel = IMM_S;
            OPC_BRANCH:           sel = IMM_B;
            OPC_LUI, OPC_AUIPC:   sel = IMM_U;
            OPC_JAL:              sel = IMM_J;
            default:              sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU operation decoder for the multi-cycle RV32I controller.
//
// Ports:
//   opcode_i   [6:0] - instruction major opcode
//   funct3_i   [2:0] - instruction funct3 field
//   funct7b5_i       - instruction bit 30 (funct7[5])
//   aluSel_o   [3:0] - ALU operation (ALU_* encoding)
module mc_alu_decoder
    import rv32i_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] aluSel_o
);

    logic [3:0] funct3Op;

    // Shared funct3 table for OP and OP-IMM. Bit 30 only picks SRA over SRL
    // here; the SUB case is handled separately below because for OP-IMM
    // bit 30 belongs to the immediate and must not turn ADDI into SUB.
    always_comb begin
        funct3Op = ALU_ADD;
        case (funct3_i)
            3'b000: funct3Op = ALU_ADD;
            3'b001: funct3Op = ALU_SLL;
            3'b010: funct3Op = ALU_SLT;
            3'b011: funct3Op = ALU_SLTU;
            3'b100: funct3Op = ALU_XOR;
            3'b101: funct3Op = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110: funct3Op = ALU_OR;
            3'b111: funct3Op = ALU_AND;
            default: funct3Op = ALU_ADD;
        endcase
    end

    // Address, link and branch-target calculations all reduce to ADD; LUI
    // just passes the U immediate through on the B port.
    always_comb begin
        aluSel_o = ALU_ADD;
        case (opcode_i)
            OPC_OP: begin
                if (funct3_i == 3'b000 && funct7b5_i)
                    aluSel_o = ALU_SUB;
                else
                    aluSel_o = funct3Op;
            end
            OPC_OPIMM: aluSel_o = funct3Op;
            OPC_LUI:   aluSel_o = ALU_COPY_B;
            default:   aluSel_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller for the RV32I core. Sequences
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over a shared ALU and a single
// memory port, and drives every datapath select and write enable.
//
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   instr     [XLEN]    - IR contents, valid from DECODE onward
//   br_taken            - branch comparator result, used in EXEC
//   mem_ready           - memory completes the current request this cycle
//   mem_req, mem_rw     - memory request and direction (1 = write)
//   pc_write, pc_sel    - PC load and source (0 = PC+4, 1 = ALU/ALU-out)
//   ir_write            - IR load
//   aluout_write        - ALU-out register load
//   reg_wen             - register-file write
//   ASel, BSel          - ALU operand selects (A: 0 rs1/1 PC, B: 0 rs2/1 imm)
//   ImmSel, ALUSel      - immediate format and ALU operation
//   WBSel               - write-back source (0 mem, 1 ALU-out, 2 PC+4)
//   illegal             - sticky illegal-instruction flag
module mc_ctrl_fsm
    import rv32i_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr,
    input  logic            br_taken,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_rw,
    output logic            pc_write,
    output logic            pc_sel,
    output logic            ir_write,
    output logic            aluout_write,
    output logic            reg_wen,
    output logic            ASel,
    output logic            BSel,
    output logic [2:0]      ImmSel,
    output logic [3:0]      ALUSel,
    output logic [1:0]      WBSel,
    output logic            illegal
);

    ctrl_state_e state_q, state_d;
    logic        illegal_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [3:0]  aluSelDec;
    logic        isStore;
    logic        isLoad;
    logic        isBranch;
    logic        isJump;
    logic        unusedInstr;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];
    assign isStore  = (opcode == OPC_STORE);
    assign isLoad   = (opcode == OPC_LOAD);
    assign isBranch = (opcode == OPC_BRANCH);
    assign isJump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);

    // Register indices and immediate bits are consumed by the datapath only.
    assign unusedInstr = ^instr;

    mc_alu_decoder uAluDecoder (
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .aluSel_o   (aluSelDec)
    );

    // Next-state selection. FETCH and MEM are the only states that wait on
    // memory; everything else advances unconditionally. HALT is a sink that
    // only reset leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_d = opcodeIsLegal(opcode) ? ST_EXEC : ST_HALT;
            ST_EXEC: begin
                if (isBranch)
                    state_d = ST_FETCH;
                else if (isLoad || isStore)
                    state_d = ST_MEM;
                else
                    state_d = ST_WB;
            end
            ST_MEM: begin
                if (mem_ready)
                    state_d = isStore ? ST_FETCH : ST_WB;
                else
                    state_d = ST_MEM;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State register and the sticky illegal flag, which is raised on the
    // same edge that enters HALT so it reads 1 for the whole HALT stay.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_HALT)
                illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;

    // Output decode from the current state and the IR. The IR is loaded on
    // the FETCH exit edge, so ImmSel in DECODE must come straight from the
    // state and IR rather than from a pre-registered copy. ImmSel is held
    // from DECODE through WB so the immediate stays stable for the whole
    // instruction. Write enables are suppressed while rst is high so a reset
    // in mid-transaction never commits a partial result.
    always_comb begin
        mem_req      = 1'b0;
        mem_rw       = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        ir_write     = 1'b0;
        aluout_write = 1'b0;
        reg_wen      = 1'b0;
        ASel         = 1'b0;
        BSel         = 1'b0;
        ImmSel       = IMM_I;
        ALUSel       = ALU_ADD;
        WBSel        = WB_MEM;
        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
            end
            ST_DECODE: begin
                ImmSel = immSelFor(opcode);
            end
            ST_EXEC: begin
                ImmSel       = immSelFor(opcode);
                aluout_write = 1'b1;
                ALUSel       = aluSelDec;
                // Branch target is PC + B-immediate, so only OP uses rs2 on
                // the ALU; the comparator has its own path to rs2.
                BSel = (opcode != OPC_OP);
                ASel = (opcode == OPC_AUIPC) || (opcode == OPC_JAL) || isBranch;
                if (isBranch) begin
                    pc_write = 1'b1;
                    pc_sel   = br_taken;
                end
            end
            ST_MEM: begin
                ImmSel  = immSelFor(opcode);
                mem_req = 1'b1;
                mem_rw  = isStore;
                if (isStore)
                    pc_write = mem_ready;
            end
            ST_WB: begin
                ImmSel   = immSelFor(opcode);
                reg_wen  = 1'b1;
                pc_write = 1'b1;
                pc_sel   = isJump;
                if (isLoad)
                    WBSel = WB_MEM;
                else if (isJump)
                    WBSel = WB_PC4;
                else
                    WBSel = WB_ALU;
            end
            default: begin
            end
        endcase
        if (rst) begin
            pc_write     = 1'b0;
            ir_write     = 1'b0;
            aluout_write = 1'b0;
            reg_wen      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed testbench for mc_ctrl_fsm. Each vector drives rst/mem_ready/
// br_taken/instr for one cycle and compares the full output bundle against
// a hand-written expectation.
module tb_mc_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_rw;
    logic        pc_write;
    logic        pc_sel;
    logic        ir_write;
    logic        aluout_write;
    logic        reg_wen;
    logic        ASel;
    logic        BSel;
    logic [2:0]  ImmSel;
    logic [3:0]  ALUSel;
    logic [1:0]  WBSel;
    logic        illegal;

    int vectorCount = 0;
    int missCount   = 0;

    logic [18:0] obsVec;

    localparam logic [31:0] ADDI   = 32'h00500093;
    localparam logic [31:0] ADD    = 32'h002081B3;
    localparam logic [31:0] SUB    = 32'h402081B3;
    localparam logic [31:0] SRAI   = 32'h4030D093;
    localparam logic [31:0] ADDIM1 = 32'hFFF00093;
    localparam logic [31:0] LUI    = 32'h123450B7;
    localparam logic [31:0] AUIPC  = 32'h00001097;
    localparam logic [31:0] JAL    = 32'h010000EF;
    localparam logic [31:0] JALR   = 32'h000080E7;
    localparam logic [31:0] LW     = 32'h0000A283;
    localparam logic [31:0] SW     = 32'h0050A223;
    localparam logic [31:0] BEQ    = 32'h00000463;
    localparam logic [31:0] BAD    = 32'hFFFFFFFF;

    mc_ctrl_fsm #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .br_taken     (br_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_rw       (mem_rw),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .ir_write     (ir_write),
        .aluout_write (aluout_write),
        .reg_wen      (reg_wen),
        .ASel         (ASel),
        .BSel         (BSel),
        .ImmSel       (ImmSel),
        .ALUSel       (ALUSel),
        .WBSel        (WBSel),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obsVec = {mem_req, mem_rw, pc_write, pc_sel, ir_write, aluout_write,
                     reg_wen, ASel, BSel, ImmSel, ALUSel, WBSel, illegal};

    // Packs an expectation in the same field order as obsVec.
    function automatic logic [18:0] pk(input logic q, input logic rw,
                                       input logic pw, input logic ps,
                                       input logic iw, input logic aw,
                                       input logic wen, input logic a,
                                       input logic b, input logic [2:0] imm,
                                       input logic [3:0] alu,
                                       input logic [1:0] wb, input logic ill);
        return {q, rw, pw, ps, iw, aw, wen, a, b, imm, alu, wb, ill};
    endfunction

    // Compares one observed bundle against its expectation.
    task automatic checkOutput(input string tag, input logic [18:0] observed,
                               input logic [18:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %05h expected %05h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks outputs mid-cycle, then advances to
    // the next falling edge.
    task automatic applyStimulus(input string tag, input logic r, input logic rdy,
                                 input logic bt, input logic [31:0] ins,
                                 input logic [18:0] expected);
        rst       = r;
        mem_ready = rdy;
        br_taken  = bt;
        instr     = ins;
        #1;
        checkOutput(tag, obsVec, expected);
        @(negedge clk);
    endtask

    // FETCH with immediate ready, then DECODE, EXEC and WB for a
    // register-writing instruction.
    task automatic runRegOp(input string tag, input logic [31:0] ins,
                            input logic [18:0] expD, input logic [18:0] expE,
                            input logic [18:0] expW);
        applyStimulus({tag, " F"}, 1'b0, 1'b1, 1'b0, ins,
                      pk(1,0,0,0,1,0,0,0,0,3'd0,4'd0,2'd0,0));
        applyStimulus({tag, " D"}, 1'b0, 1'b1, 1'b0, ins, expD);
        applyStimulus({tag, " E"}, 1'b0, 1'b1, 1'b0, ins, expE);
        applyStimulus({tag, " W"}, 1'b0, 1'b1, 1'b0, ins, expW);
    endtask

    initial begin
        logic [18:0] fetchWait;
        logic [18:0] fetchGo;
        logic [18:0] allZero;
        logic [18:0] wbAlu;
        fetchWait = pk(1,0,0,0,0,0,0,0,0,3'd0,4'd0,2'd0,0);
        fetchGo   = pk(1,0,0,0,1,0,0,0,0,3'd0,4'd0,2'd0,0);
        allZero   = pk(0,0,0,0,0,0,0,0,0,3'd0,4'd0,2'd0,0);
        wbAlu     = pk(0,0,1,0,0,0,1,0,0,3'd0,4'd0,2'd1,0);

        rst = 1'b1; mem_ready = 1'b0; br_taken = 1'b0; instr = 32'h0;
        @(negedge clk);
        $display("[TB] reset checks");
        applyStimulus("reset fetch", 1, 0, 0, 32'h0, fetchWait);
        applyStimulus("reset irw gated", 1, 1, 0, 32'h0, fetchWait);
        applyStimulus("fetch stall", 0, 0, 0, 32'h0, fetchWait);

        $display("[TB] register-writing instructions");
        runRegOp("addi", ADDI, allZero,
                 pk(0,0,0,0,0,1,0,0,1,3'd0,4'd0,2'd0,0), wbAlu);
        runRegOp("add", ADD, allZero,
                 pk(0,0,0,0,0,1,0,0,0,3'd0,4'd0,2'd0,0), wbAlu);
        runRegOp("sub", SUB, allZero,
                 pk(0,0,0,0,0,1,0,0,0,3'd0,4'd1,2'd0,0), wbAlu);
        runRegOp("srai", SRAI, allZero,
                 pk(0,0,0,0,0,1,0,0,1,3'd0,4'd7,2'd0,0), wbAlu);
        runRegOp("addi -1", ADDIM1, allZero,
                 pk(0,0,0,0,0,1,0,0,1,3'd0,4'd0,2'd0,0), wbAlu);
        runRegOp("lui", LUI, pk(0,0,0,0,0,0,0,0,0,3'd3,4'd0,2'd0,0),
                 pk(0,0,0,0,0,1,0,0,1,3'd3,4'd10,2'd0,0),
                 pk(0,0,1,0,0,0,1,0,0,3'd3,4'd0,2'd1,0));
        runRegOp("auipc", AUIPC, pk(0,0,0,0,0,0,0,0,0,3'd3,4'd0,2'd0,0),
                 pk(0,0,0,0,0,1,0,1,1,3'd3,4'd0,2'd0,0),
                 pk(0,0,1,0,0,0,1,0,0,3'd3,4'd0,2'd1,0));
        runRegOp("jal", JAL, pk(0,0,0,0,0,0,0,0,0,3'd4,4'd0,2'd0,0),
                 pk(0,0,0,0,0,1,0,1,1,3'd4,4'd0,2'd0,0),
                 pk(0,0,1,1,0,0,1,0,0,3'd4,4'd0,2'd2,0));
        runRegOp("jalr", JALR, allZero,
                 pk(0,0,0,0,0,1,0,0,1,3'd0,4'd0,2'd0,0),
                 pk(0,0,1,1,0,0,1,0,0,3'd0,4'd0,2'd2,0));

        $display("[TB] load with two stall cycles");
        applyStimulus("lw F", 0, 1, 0, LW, fetchGo);
        applyStimulus("lw D", 0, 0, 0, LW, allZero);
        applyStimulus("lw E", 0, 0, 0, LW, pk(0,0,0,0,0,1,0,0,1,3'd0,4'd0,2'd0,0));
        applyStimulus("lw M wait1", 0, 0, 0, LW, fetchWait);
        applyStimulus("lw M wait2", 0, 0, 0, LW, fetchWait);
        applyStimulus("lw M done", 0, 1, 0, LW, fetchWait);
        applyStimulus("lw W", 0, 0, 0, LW, pk(0,0,1,0,0,0,1,0,0,3'd0,4'd0,2'd0,0));

        $display("[TB] store with one stall cycle");
        applyStimulus("sw F", 0, 1, 0, SW, fetchGo);
        applyStimulus("sw D", 0, 1, 0, SW, pk(0,0,0,0,0,0,0,0,0,3'd1,4'd0,2'd0,0));
        applyStimulus("sw E", 0, 1, 0, SW, pk(0,0,0,0,0,1,0,0,1,3'd1,4'd0,2'd0,0));
        applyStimulus("sw M wait", 0, 0, 0, SW, pk(1,1,0,0,0,0,0,0,0,3'd1,4'd0,2'd0,0));
        applyStimulus("sw M done", 0, 1, 0, SW, pk(1,1,1,0,0,0,0,0,0,3'd1,4'd0,2'd0,0));
        applyStimulus("sw next F", 0, 0, 0, SW, fetchWait);

        $display("[TB] branches");
        applyStimulus("beq t F", 0, 1, 0, BEQ, fetchGo);
        applyStimulus("beq t D", 0, 1, 1, BEQ, pk(0,0,0,0,0,0,0,0,0,3'd2,4'd0,2'd0,0));
        applyStimulus("beq t E", 0, 1, 1, BEQ, pk(0,0,1,1,0,1,0,1,1,3'd2,4'd0,2'd0,0));
        applyStimulus("beq t next F", 0, 1, 0, BEQ, fetchGo);
        applyStimulus("beq n D", 0, 1, 0, BEQ, pk(0,0,0,0,0,0,0,0,0,3'd2,4'd0,2'd0,0));
        applyStimulus("beq n E", 0, 1, 0, BEQ, pk(0,0,1,0,0,1,0,1,1,3'd2,4'd0,2'd0,0));

        $display("[TB] illegal instruction");
        applyStimulus("ill F", 0, 1, 0, BAD, fetchGo);
        applyStimulus("ill D", 0, 1, 0, BAD, allZero);
        applyStimulus("ill H1", 0, 1, 1, BAD, pk(0,0,0,0,0,0,0,0,0,3'd0,4'd0,2'd0,1));
        applyStimulus("ill H2", 0, 1, 0, ADDI, pk(0,0,0,0,0,0,0,0,0,3'd0,4'd0,2'd0,1));
        applyStimulus("ill H3", 0, 0, 0, ADDI, pk(0,0,0,0,0,0,0,0,0,3'd0,4'd0,2'd0,1));
        applyStimulus("ill H rst", 1, 1, 0, ADDI, pk(0,0,0,0,0,0,0,0,0,3'd0,4'd0,2'd0,1));
        applyStimulus("ill after rst", 0, 0, 0, ADDI, fetchWait);

        $display("[TB] reset during memory stalls");
        applyStimulus("rlw F", 0, 1, 0, LW, fetchGo);
        applyStimulus("rlw D", 0, 0, 0, LW, allZero);
        applyStimulus("rlw E", 0, 0, 0, LW, pk(0,0,0,0,0,1,0,0,1,3'd0,4'd0,2'd0,0));
        applyStimulus("rlw M wait", 0, 0, 0, LW, fetchWait);
        applyStimulus("rlw M rst", 1, 1, 0, LW, fetchWait);
        applyStimulus("rlw after rst", 0, 0, 0, LW, fetchWait);
        applyStimulus("rsw F", 0, 1, 0, SW, fetchGo);
        applyStimulus("rsw D", 0, 0, 0, SW, pk(0,0,0,0,0,0,0,0,0,3'd1,4'd0,2'd0,0));
        applyStimulus("rsw E", 0, 0, 0, SW, pk(0,0,0,0,0,1,0,0,1,3'd1,4'd0,2'd0,0));
        applyStimulus("rsw M rst", 1, 1, 0, SW, pk(1,1,0,0,0,0,0,0,0,3'd1,4'd0,2'd0,0));
        applyStimulus("rsw after rst", 0, 0, 0, SW, fetchWait);
        applyStimulus("rsw resume", 0, 1, 0, SW, fetchGo);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
